// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-flop synchronized input, centre-of-bit sampling.
// Emits a one-clock rx_done_tick on a good stop bit, or frame_err on a bad one.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DIVISOR = 27
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned SMAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned SW   = $clog2(SMAX);
    localparam int unsigned NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic            tick;
    logic            fall;

    // Synchronizer and edge history idle high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    // Free-running oversample tick generator.
    assign tick  = (cnt_q == CW'(DIVISOR - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s_q) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        shreg_d = {rx_s_q, shreg_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = StIdle;
                        if (rx_s_q) begin
                            dout_d = shreg_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model (expected byte / error queue)
// checked against the DUT every clock, with directed and random frames.
module tb_uart_rx;

    localparam int DIV = 27;
    localparam int BIT = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dout;
    logic       done;
    logic       ferr;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16),
        .DIVISOR (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (done),
        .frame_err    (ferr),
        .busy         (busy)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    exp_t       exp_q[$];
    logic [7:0] model_dout = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison against the frame-level model.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            model_dout = 8'h00;
            chk("reset_outputs", {dout, done, ferr, busy}, 32'h0);
        end else begin
            if (done || ferr) begin
                chk("done_ferr_exclusive", {31'h0, done & ferr}, 32'h0);
                if (done) done_cnt++;
                if (ferr) ferr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'h0, done, ferr}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {31'h0, ferr}, {31'h0, e.err});
                    if (!e.err) model_dout = e.data;
                end
            end
            chk("dout_value", {24'h0, dout}, {24'h0, model_dout});
        end
    end

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * BIT) @(negedge clk);
    endtask

    // 8N1 frame; line is left at the stop level so the next call can start back-to-back.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        exp_t e;
        e.err  = ~stop;
        e.data = b;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        chk("frame_deadline", exp_q.size(), 32'h0);
    endtask

    task automatic set_rst(input logic v);
        @(negedge clk);
        #2 rst = v;
    endtask

    int         d0;
    int         f0;
    logic [7:0] lb[4];
    logic [7:0] rb;
    logic       rs;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_dout", {24'h0, dout}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        set_rst(1'b0);
        idle(1);

        // Single byte.
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hBB, 1'b1);
        chk("bb_dout", {24'h0, dout}, 32'hBB);
        chk("bb_done_cnt", done_cnt - d0, 1);
        chk("bb_ferr_cnt", ferr_cnt - f0, 0);

        // Back-to-back.
        d0 = done_cnt;
        send_frame(8'hE7, 1'b1);
        chk("b2b_e7", {24'h0, dout}, 32'hE7);
        send_frame(8'hFF, 1'b1);
        chk("b2b_ff", {24'h0, dout}, 32'hFF);
        send_frame(8'h00, 1'b1);
        chk("b2b_00", {24'h0, dout}, 32'h00);
        chk("b2b_done_cnt", done_cnt - d0, 3);

        // Short low glitch on idle line.
        idle(1);
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy_high", {31'h0, busy}, 1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (160) @(negedge clk);
        chk("glitch_busy_low", {31'h0, busy}, 0);
        idle(1);
        chk("glitch_no_done", done_cnt - d0, 0);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);

        // Bad stop bit followed by a break.
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        chk("ferr_cnt", ferr_cnt - f0, 1);
        chk("ferr_no_done", done_cnt - d0, 0);
        chk("ferr_dout_kept", {24'h0, dout}, 32'h00);
        repeat (3 * BIT) @(negedge clk);
        chk("break_busy", {31'h0, busy}, 0);
        chk("break_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 1);
        idle(1);

        // Reset in the middle of bit 4 of 0xA5.
        rb = 8'hA5;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            repeat (BIT) @(negedge clk);
        end
        rx = rb[4];
        repeat (BIT / 2) @(negedge clk);
        d0 = done_cnt; f0 = ferr_cnt;
        set_rst(1'b1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_dout", {24'h0, dout}, 32'h0);
        set_rst(1'b0);
        idle(2);
        chk("midrst_busy", {31'h0, busy}, 0);
        chk("midrst_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
        send_frame(8'h3C, 1'b1);
        chk("after_rst_dout", {24'h0, dout}, 32'h3C);
        chk("after_rst_done", done_cnt - d0, 1);

        // Loopback-style transmit of a byte sequence.
        idle(1);
        lb[0] = 8'hBB; lb[1] = 8'hE7; lb[2] = 8'hFF; lb[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send_frame(lb[i], 1'b1);
            chk("loopback_byte", {24'h0, dout}, {24'h0, lb[i]});
        end

        // Random frames with occasional bad stop bits.
        for (int i = 0; i < 5; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs);
            if (!rs || ($urandom_range(0, 1) == 1)) idle(1);
        end

        idle(1);
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters:
REQ-001 SHALL provide parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL provide parameter SB_TICK, default 16, stop-bit length in oversample ticks (16 = 1 stop bit).
REQ-003 SHALL provide parameter DIVISOR, default 27, clk cycles per oversample tick (50 MHz / (115200 x 16)).

Ports:
REQ-004 SHALL provide port clk, input, 1, single system clock; all state on rising edge.
REQ-005 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port rx, input, 1, asynchronous serial line; idle high.
REQ-007 SHALL provide port dout, output, DBIT, last correctly framed byte.
REQ-008 SHALL provide port rx_done_tick, output, 1, one-clk pulse when dout updates.
REQ-009 SHALL provide port frame_err, output, 1, one-clk pulse on a bad stop bit.
REQ-010 SHALL provide port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
REQ-012 SHALL generate a one-clk tick every DIVISOR clks from a free-running counter (0..DIVISOR-1, wraps).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; tick counter s (0..15) and bit counter n (0..DBIT-1).
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0) SHALL go to START with s=0; a level-low rx_s without an edge SHALL NOT start a frame.
REQ-015 START: on tick with s==7, SHALL go to DATA with s=0 and n=0 if rx_s==0; if rx_s==1 (glitch), SHALL return to IDLE without any output pulse; other ticks increment s.
REQ-016 DATA: on tick with s==15, SHALL shift rx_s into shift register MSB, shifting right (LSB received first), and set s=0; after bit n==DBIT-1 SHALL go to STOP.
REQ-017 STOP: on tick with s==SB_TICK-1, SHALL sample rx_s; if 1, dout <= shift register and rx_done_tick=1 for exactly one clk; if 0, frame_err=1 for one clk with dout unchanged; both cases go to IDLE.
REQ-018 rx_done_tick and frame_err SHALL never be high together; each SHALL be high for one clk per frame at most.
REQ-019 Back-to-back frames (next start edge immediately after stop sample) SHALL be received with no lost byte.
REQ-020 After a framing error with rx held low (break), SHALL stay in IDLE until rx_s returns high and falls again.
REQ-021 Sampling occurs at bit centre: start check at 8 ticks after edge detect, each data/stop bit 16 ticks later.
REQ-022 dout SHALL be registered and stable between rx_done_tick pulses.

Reset
REQ-023 While rst=1, SHALL force state=IDLE, s=0, n=0, shift register=0, tick counter=0, synchronizer=1, edge history=1.
REQ-024 SHALL reset outputs: dout=0, rx_done_tick=0, frame_err=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception SHALL resume on the next falling edge.

Verification
REQ-026 Bench SHALL send 0xBB (8N1, 432 clks/bit, defaults) -> one rx_done_tick, dout=0xBB, frame_err=0.
REQ-027 Bench SHALL send 0xE7, 0xFF, 0x00 back-to-back, one stop bit each -> three rx_done_tick pulses with dout 0xE7, 0xFF, 0x00 in order.
REQ-028 Bench SHALL drive a 100-clk low glitch on idle rx -> no rx_done_tick, no frame_err, busy returns to 0 within 8 ticks.
REQ-029 Bench SHALL send 0x55 with stop bit low -> frame_err pulse, dout keeps the prior value, no rx_done_tick; rx then held low -> no new frame until high then falling.
REQ-030 Bench SHALL assert rst during bit 4 of 0xA5, then send 0x3C -> no pulse for 0xA5; dout=0x3C with one rx_done_tick.
REQ-031 Bench SHALL perform a loopback from the team's UART transmitter (same DIVISOR) sending 0xBB, 0xE7, 0xFF, 0x00 -> each received byte equals the sent byte.
